// File: rtl/char_spawn_ctrl.sv
// Slot manager for the falling-character game: spawns characters on a frame-tick cadence,
// moves them down each frame and retires them on a matching keypress (hit) or at the bottom (miss).
module char_spawn_ctrl #(
    parameter int          SLOTS          = 8,
    parameter int          SPAWN_INTERVAL = 60,
    parameter logic [8:0]  X_LIMIT        = 9'd460,
    parameter logic [15:0] MISS_LIMIT     = 16'd10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             frame_tick,
    input  logic [7:0]       gen_ch,
    input  logic [2:0]       gen_speed,
    input  logic [8:0]       gen_x,
    input  logic [9:0]       gen_y,
    input  logic             key_valid,
    input  logic [7:0]       key_code,
    input  logic [3:0]       rd_idx,
    output logic             rd_valid,
    output logic [7:0]       rd_ch,
    output logic [8:0]       rd_x,
    output logic [9:0]       rd_y,
    output logic [SLOTS-1:0] slot_valid,
    output logic             hit,
    output logic             wrong,
    output logic             miss,
    output logic             drop,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count,
    output logic             game_over
);

    localparam int CNT_W = $clog2(SPAWN_INTERVAL + 1);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    typedef struct packed {
        logic [7:0] ch;
        logic [8:0] x;
        logic [9:0] y;
        logic [2:0] speed;
    } slot_t;

    state_t           state, state_n;
    slot_t            slots   [SLOTS];
    slot_t            slots_n [SLOTS];
    logic [SLOTS-1:0] valid, valid_n;
    logic [CNT_W-1:0] spawn_cnt, spawn_cnt_n;
    logic             spawn_pending, spawn_pending_n;
    logic             hit_n, wrong_n, miss_n, drop_n;
    logic [15:0]      hit_count_n, miss_count_n;
    logic             key_match, spawned;
    logic [9:0]       nx;
    logic [4:0]       retired;
    logic [16:0]      miss_sum;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_n         = state;
        slots_n         = slots;
        valid_n         = valid;
        spawn_cnt_n     = spawn_cnt;
        spawn_pending_n = spawn_pending;
        hit_n           = 1'b0;
        wrong_n         = 1'b0;
        miss_n          = 1'b0;
        drop_n          = 1'b0;
        hit_count_n     = hit_count;
        miss_count_n    = miss_count;
        key_match       = 1'b0;
        spawned         = 1'b0;
        nx              = '0;
        retired         = '0;
        miss_sum        = '0;

        unique case (state)
            IDLE: if (enable) state_n = RUN;
            RUN: if (enable) begin
                if (miss_count >= MISS_LIMIT) begin
                    state_n = OVER;
                end else begin
                    if (key_valid) begin
                        for (int i = 0; i < SLOTS; i++) begin
                            if (!key_match && valid[i] && slots[i].ch == key_code) begin
                                key_match  = 1'b1;
                                valid_n[i] = 1'b0;
                            end
                        end
                        if (key_match) begin
                            hit_n       = 1'b1;
                            hit_count_n = (hit_count == 16'hFFFF) ? hit_count : hit_count + 16'd1;
                        end else begin
                            wrong_n = 1'b1;
                        end
                    end

                    if (frame_tick) begin
                        if (spawn_cnt == CNT_W'(SPAWN_INTERVAL - 1)) begin
                            spawn_cnt_n     = '0;
                            spawn_pending_n = 1'b1;
                        end else begin
                            spawn_cnt_n = spawn_cnt + CNT_W'(1);
                        end
                        // Walking valid_n means a slot hit this cycle neither moves nor misses.
                        for (int i = 0; i < SLOTS; i++) begin
                            if (valid_n[i]) begin
                                nx = {1'b0, slots[i].x} + {7'd0, slots[i].speed};
                                if (nx >= {1'b0, X_LIMIT}) begin
                                    valid_n[i] = 1'b0;
                                    retired    = retired + 5'd1;
                                end else begin
                                    slots_n[i].x = nx[8:0];
                                end
                            end
                        end
                        if (retired != 5'd0) begin
                            miss_n       = 1'b1;
                            miss_sum     = {1'b0, miss_count} + {12'd0, retired};
                            miss_count_n = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
                        end
                    end else if (spawn_pending && !key_valid) begin
                        spawn_pending_n = 1'b0;
                        for (int i = 0; i < SLOTS; i++) begin
                            if (!spawned && !valid[i]) begin
                                spawned    = 1'b1;
                                valid_n[i] = 1'b1;
                                slots_n[i] = '{ch: gen_ch, x: gen_x, y: gen_y,
                                               speed: (gen_speed == 3'd0) ? 3'd1 : gen_speed};
                            end
                        end
                        if (!spawned) drop_n = 1'b1;
                    end
                end
            end
            OVER:    state_n = OVER;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            valid         <= '0;
            spawn_cnt     <= '0;
            spawn_pending <= 1'b0;
            hit           <= 1'b0;
            wrong         <= 1'b0;
            miss          <= 1'b0;
            drop          <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
            // NOTE: slot payload is reset as well because the renderer reads it straight out.
            for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state         <= state_n;
            valid         <= valid_n;
            spawn_cnt     <= spawn_cnt_n;
            spawn_pending <= spawn_pending_n;
            hit           <= hit_n;
            wrong         <= wrong_n;
            miss          <= miss_n;
            drop          <= drop_n;
            hit_count     <= hit_count_n;
            miss_count    <= miss_count_n;
            for (int i = 0; i < SLOTS; i++) slots[i] <= slots_n[i];
        end
    end

    assign slot_valid = valid;
    assign game_over  = (state == OVER);

    always_comb begin
        rd_valid = 1'b0;
        rd_ch    = '0;
        rd_x     = '0;
        rd_y     = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (rd_idx == 4'(i)) begin
                rd_valid = valid[i];
                rd_ch    = slots[i].ch;
                rd_x     = slots[i].x;
                rd_y     = slots[i].y;
            end
        end
    end

endmodule

// File: tb/tb_char_spawn_ctrl.sv
// Bench for char_spawn_ctrl: directed scenarios plus a randomized run, all checked against
// a slot-list reference model built from the game rules.
module tb_char_spawn_ctrl;

    localparam int SLOTS = 8;
    localparam int SPAWN = 2;
    localparam int XL    = 460;
    localparam int MLIM  = 10;

    logic             clk = 1'b0;
    logic             rst, enable, frame_tick, key_valid;
    logic [7:0]       gen_ch, key_code;
    logic [2:0]       gen_speed;
    logic [8:0]       gen_x;
    logic [9:0]       gen_y;
    logic [3:0]       rd_idx;
    logic             rd_valid;
    logic [7:0]       rd_ch;
    logic [8:0]       rd_x;
    logic [9:0]       rd_y;
    logic [SLOTS-1:0] slot_valid;
    logic             hit, wrong, miss, drop, game_over;
    logic [15:0]      hit_count, miss_count;

    int vectors = 0;
    int errors  = 0;

    // Reference model: plain integers per slot, game phase 0=idle 1=run 2=over.
    int m_state, m_cnt, m_hits, m_misses;
    bit m_pend, m_hit, m_wrong, m_miss, m_drop;
    bit m_valid [SLOTS];
    int m_ch [SLOTS], m_x [SLOTS], m_y [SLOTS], m_sp [SLOTS];

    char_spawn_ctrl #(
        .SLOTS(SLOTS), .SPAWN_INTERVAL(SPAWN), .X_LIMIT(9'd460), .MISS_LIMIT(16'd10)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
        .gen_ch(gen_ch), .gen_speed(gen_speed), .gen_x(gen_x), .gen_y(gen_y),
        .key_valid(key_valid), .key_code(key_code), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_x(rd_x), .rd_y(rd_y),
        .slot_valid(slot_valid), .hit(hit), .wrong(wrong), .miss(miss), .drop(drop),
        .hit_count(hit_count), .miss_count(miss_count), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic void model_update(bit r, bit en, bit tk, bit kv, int kc);
        int hs;
        int n;
        int fs;
        if (r) begin
            m_state = 0; m_cnt = 0; m_hits = 0; m_misses = 0; m_pend = 0;
            m_hit = 0; m_wrong = 0; m_miss = 0; m_drop = 0;
            for (int i = 0; i < SLOTS; i++) begin
                m_valid[i] = 0; m_ch[i] = 0; m_x[i] = 0; m_y[i] = 0; m_sp[i] = 0;
            end
            return;
        end
        m_hit = 0; m_wrong = 0; m_miss = 0; m_drop = 0;
        if (m_state == 0) begin
            if (en) m_state = 1;
        end else if (m_state == 1 && en) begin
            if (m_misses >= MLIM) begin
                m_state = 2;
            end else begin
                hs = -1;
                if (kv) begin
                    for (int i = SLOTS - 1; i >= 0; i--)
                        if (m_valid[i] && m_ch[i] == kc) hs = i;
                    if (hs >= 0) begin
                        m_valid[hs] = 0;
                        m_hit  = 1;
                        m_hits = (m_hits < 65535) ? m_hits + 1 : 65535;
                    end else begin
                        m_wrong = 1;
                    end
                end
                if (tk) begin
                    m_cnt++;
                    if (m_cnt == SPAWN) begin m_cnt = 0; m_pend = 1; end
                    n = 0;
                    for (int i = 0; i < SLOTS; i++) begin
                        if (m_valid[i]) begin
                            if (m_x[i] + m_sp[i] >= XL) begin m_valid[i] = 0; n++; end
                            else m_x[i] += m_sp[i];
                        end
                    end
                    if (n > 0) begin
                        m_miss   = 1;
                        m_misses = (m_misses + n > 65535) ? 65535 : m_misses + n;
                    end
                end else if (m_pend && !kv) begin
                    m_pend = 0;
                    fs = -1;
                    for (int i = SLOTS - 1; i >= 0; i--) if (!m_valid[i]) fs = i;
                    if (fs < 0) m_drop = 1;
                    else begin
                        m_valid[fs] = 1; m_ch[fs] = int'(gen_ch); m_x[fs] = int'(gen_x);
                        m_y[fs] = int'(gen_y); m_sp[fs] = (gen_speed == 0) ? 1 : int'(gen_speed);
                    end
                end
            end
        end
    endfunction

    function automatic logic [SLOTS-1:0] model_vec();
        logic [SLOTS-1:0] v;
        for (int i = 0; i < SLOTS; i++) v[i] = m_valid[i];
        return v;
    endfunction

    task automatic step(input bit r, input bit en, input bit tk, input bit kv, input logic [7:0] kc);
        rst = r; enable = en; frame_tick = tk; key_valid = kv; key_code = kc;
        model_update(r, en, tk, kv, int'(kc));
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int idx);
        rd_idx = 4'(idx);
        #1;
    endtask

    task automatic begin_run();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    // Two ticks make a spawn due; the following quiet cycle executes it.
    task automatic spawn_one(input logic [7:0] c, input logic [2:0] sp, input logic [8:0] x, input logic [9:0] y);
        gen_ch = c; gen_speed = sp; gen_x = x; gen_y = y;
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        begin_run();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        vectors++;
        if (slot_valid !== '0 || hit_count !== 16'd0 || miss_count !== 16'd0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%h hits=%0d misses=%0d over=%b, want 00/0/0/0",
                     slot_valid, hit_count, miss_count, game_over);
        end
        vectors++;
        if ({hit, wrong, miss, drop} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses: got %b want 0000", {hit, wrong, miss, drop});
        end
        rd(0);
        vectors++;
        if ({rd_valid, rd_ch, rd_x, rd_y} !== '0) begin
            errors++; $display("FAIL reset_read: valid=%b ch=%h x=%0d y=%0d want zeros", rd_valid, rd_ch, rd_x, rd_y);
        end
    endtask

    task automatic test_spawn();
        begin_run();
        gen_ch = 8'h41; gen_speed = 3'd0; gen_x = 9'd0; gen_y = 10'd100;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        vectors++;
        if (slot_valid !== 8'h03) begin
            errors++; $display("FAIL spawn_valid: got %h want 03", slot_valid);
        end
        rd(0);
        vectors++;
        if (rd_valid !== 1'b1 || rd_ch !== 8'h41 || rd_x !== 9'd2 || rd_y !== 10'd100) begin
            errors++; $display("FAIL spawn_slot0: v=%b ch=%h x=%0d y=%0d want 1/41/2/100", rd_valid, rd_ch, rd_x, rd_y);
        end
        rd(1);
        vectors++;
        if (rd_valid !== 1'b1 || rd_ch !== 8'h41 || rd_x !== 9'd0) begin
            errors++; $display("FAIL spawn_slot1: v=%b ch=%h x=%0d want 1/41/0", rd_valid, rd_ch, rd_x);
        end
        rd(9);
        vectors++;
        if ({rd_valid, rd_ch, rd_x, rd_y} !== '0) begin
            errors++; $display("FAIL read_out_of_range: v=%b ch=%h want zeros", rd_valid, rd_ch);
        end
    endtask

    task automatic test_hit_wrong();
        begin_run();
        spawn_one(8'h42, 3'd1, 9'd0, 10'd10);
        spawn_one(8'h43, 3'd1, 9'd0, 10'd20);
        spawn_one(8'h42, 3'd1, 9'd0, 10'd30);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h42);
        vectors++;
        if (slot_valid !== 8'h06 || hit !== 1'b1 || wrong !== 1'b0 || hit_count !== 16'd1) begin
            errors++; $display("FAIL hit_lowest: valid=%h hit=%b wrong=%b hits=%0d want 06/1/0/1",
                               slot_valid, hit, wrong, hit_count);
        end
        rd(2);
        vectors++;
        if (rd_valid !== 1'b1 || rd_ch !== 8'h42) begin
            errors++; $display("FAIL hit_retain: v=%b ch=%h want 1/42", rd_valid, rd_ch);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);
        vectors++;
        if (slot_valid !== 8'h06 || wrong !== 1'b1 || hit !== 1'b0 || hit_count !== 16'd1) begin
            errors++; $display("FAIL wrong_key: valid=%h wrong=%b hit=%b hits=%0d want 06/1/0/1",
                               slot_valid, wrong, hit, hit_count);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        vectors++;
        if ({hit, wrong} !== 2'b00) begin
            errors++; $display("FAIL pulse_width: hit/wrong=%b want 00", {hit, wrong});
        end
    endtask

    task automatic test_miss();
        begin_run();
        spawn_one(8'h4D, 3'd3, 9'd452, 10'd20);
        spawn_one(8'h4E, 3'd3, 9'd458, 10'd30);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        vectors++;
        if (slot_valid !== 8'h00 || miss !== 1'b1 || miss_count !== 16'd2) begin
            errors++; $display("FAIL double_miss: valid=%h miss=%b misses=%0d want 00/1/2", slot_valid, miss, miss_count);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        vectors++;
        if (miss !== 1'b0) begin
            errors++; $display("FAIL miss_width: got %b want 0", miss);
        end
    endtask

    task automatic test_same_cycle();
        begin_run();
        spawn_one(8'h51, 3'd3, 9'd458, 10'd40);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h51);
        vectors++;
        if (hit !== 1'b1 || miss !== 1'b0 || miss_count !== 16'd0 || hit_count !== 16'd1 || slot_valid !== 8'h00) begin
            errors++; $display("FAIL key_before_tick: hit=%b miss=%b misses=%0d hits=%0d valid=%h want 1/0/0/1/00",
                               hit, miss, miss_count, hit_count, slot_valid);
        end
    endtask

    task automatic test_drop();
        begin_run();
        for (int k = 0; k < SLOTS; k++) spawn_one(8'(8'h61 + k), 3'd1, 9'd0, 10'(k * 8));
        gen_ch = 8'h7A;
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        vectors++;
        if (drop !== 1'b1 || slot_valid !== 8'hFF) begin
            errors++; $display("FAIL drop_full: drop=%b valid=%h want 1/FF", drop, slot_valid);
        end
        rd(7);
        vectors++;
        if (rd_ch !== 8'h68) begin
            errors++; $display("FAIL drop_untouched: ch=%h want 68", rd_ch);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        vectors++;
        if (drop !== 1'b0) begin
            errors++; $display("FAIL drop_width: got %b want 0", drop);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h64);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        vectors++;
        if (slot_valid !== 8'hF7) begin
            errors++; $display("FAIL drop_timer_restart: valid=%h want F7", slot_valid);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        rd(3);
        vectors++;
        if (slot_valid !== 8'hFF || rd_ch !== 8'h7A) begin
            errors++; $display("FAIL refill_lowest: valid=%h ch3=%h want FF/7A", slot_valid, rd_ch);
        end
    endtask

    task automatic test_game_over();
        begin_run();
        gen_ch = 8'h5A; gen_speed = 3'd1; gen_x = 9'd459; gen_y = 10'd0;
        for (int c = 0; c < 400 && game_over !== 1'b1; c++)
            step(1'b0, 1'b1, (c % 2 == 0), 1'b0, 8'h00);
        vectors++;
        if (game_over !== 1'b1 || miss_count !== 16'd10) begin
            errors++; $display("FAIL game_over_reach: over=%b misses=%0d want 1/10", game_over, miss_count);
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, (k % 2 == 0), 1'b1, 8'h5A);
            vectors++;
            if (slot_valid !== model_vec() || {hit, wrong, miss, drop} !== 4'b0000 ||
                miss_count !== 16'd10 || hit_count !== 16'd0 || game_over !== 1'b1) begin
                errors++; $display("FAIL over_frozen: valid=%h/%h pulses=%b misses=%0d hits=%0d over=%b",
                                   slot_valid, model_vec(), {hit, wrong, miss, drop}, miss_count, hit_count, game_over);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        vectors++;
        if (game_over !== 1'b0 || miss_count !== 16'd0) begin
            errors++; $display("FAIL over_reset: over=%b misses=%0d want 0/0", game_over, miss_count);
        end
    endtask

    task automatic test_reset_mid();
        begin_run();
        for (int k = 0; k < 5; k++) spawn_one(8'(8'h61 + k), 3'd2, 9'd0, 10'd5);
        vectors++;
        if (slot_valid !== 8'h1F) begin
            errors++; $display("FAIL midreset_setup: valid=%h want 1F", slot_valid);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h61);
        vectors++;
        if (slot_valid !== 8'h00 || {hit, wrong, miss, drop} !== 4'b0000 || hit_count !== 16'd0 ||
            miss_count !== 16'd0 || game_over !== 1'b0) begin
            errors++; $display("FAIL midreset_clear: valid=%h pulses=%b hits=%0d misses=%0d over=%b",
                               slot_valid, {hit, wrong, miss, drop}, hit_count, miss_count, game_over);
        end
        rd(0);
        vectors++;
        if ({rd_valid, rd_ch, rd_x, rd_y} !== '0) begin
            errors++; $display("FAIL midreset_payload: ch=%h x=%0d y=%0d want zeros", rd_ch, rd_x, rd_y);
        end
    endtask

    task automatic test_random();
        bit r, en, tk, kv;
        logic [7:0] kc;
        int idx;
        begin_run();
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            en = ($urandom_range(0, 9) != 0);
            tk = ($urandom_range(0, 3) == 0);
            kv = ($urandom_range(0, 4) == 0);
            kc = 8'(8'h41 + $urandom_range(0, 4));
            gen_ch    = 8'(8'h41 + $urandom_range(0, 3));
            gen_speed = 3'($urandom_range(0, 7));
            gen_x     = 9'($urandom_range(0, 511));
            gen_y     = 10'($urandom_range(0, 1023));
            step(r, en, tk, kv, kc);
            idx = int'($urandom_range(0, 15));
            rd(idx);
            vectors++;
            if (slot_valid !== model_vec() || {hit, wrong, miss, drop} !== {m_hit, m_wrong, m_miss, m_drop} ||
                hit_count !== 16'(m_hits) || miss_count !== 16'(m_misses) || game_over !== (m_state == 2)) begin
                errors++; $display("FAIL random_state[%0d]: valid=%h/%h pulses=%b/%b hits=%0d/%0d misses=%0d/%0d over=%b",
                                   n, slot_valid, model_vec(), {hit, wrong, miss, drop},
                                   {m_hit, m_wrong, m_miss, m_drop}, hit_count, m_hits, miss_count, m_misses, game_over);
            end
            vectors++;
            if (idx >= SLOTS) begin
                if ({rd_valid, rd_ch, rd_x, rd_y} !== '0) begin
                    errors++; $display("FAIL random_read_oor[%0d]: idx=%0d v=%b ch=%h want zeros", n, idx, rd_valid, rd_ch);
                end
            end else if (rd_valid !== m_valid[idx] ||
                         (m_valid[idx] && (rd_ch !== 8'(m_ch[idx]) || rd_x !== 9'(m_x[idx]) || rd_y !== 10'(m_y[idx])))) begin
                errors++; $display("FAIL random_read[%0d]: idx=%0d v=%b ch=%h x=%0d y=%0d want %b/%h/%0d/%0d",
                                   n, idx, rd_valid, rd_ch, rd_x, rd_y, m_valid[idx], m_ch[idx], m_x[idx], m_y[idx]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; key_valid = 1'b0; key_code = 8'h00;
        gen_ch = 8'h00; gen_speed = 3'd0; gen_x = 9'd0; gen_y = 10'd0; rd_idx = 4'd0;
        test_reset();
        test_spawn();
        test_hit_wrong();
        test_miss();
        test_same_cycle();
        test_drop();
        test_game_over();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/char_spawn_ctrl.md
Name: char_spawn_ctrl

Overview:
- Scheduler and slot manager for the falling-character generator.
- Holds up to SLOTS active characters. Samples the generator's ch/speed/x/y outputs on a fixed frame-tick cadence to spawn new ones, and advances each character downward once per frame.
- Retires characters on a matching keypress (hit) or on reaching the bottom (miss).
- Sits between the generator, the keyboard decoder and the VGA renderer; the renderer reads slots through a combinational read port.

Parameters:
- SLOTS, 8: number of character slots (2..16).
- SPAWN_INTERVAL, 60: frame ticks between spawn attempts (>=1).
- X_LIMIT, 9'd460: vertical position at or beyond which a character is missed.
- MISS_LIMIT, 16'd10: miss count that ends the game.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  run gate; low freezes all state updates except reset
- frame_tick  in  1  one-cycle pulse per video frame
- gen_ch  in  8  generator character (ASCII)
- gen_speed  in  3  generator speed, pixels/frame
- gen_x  in  9  generator start row
- gen_y  in  10  generator column
- key_valid  in  1  one-cycle keypress strobe
- key_code  in  8  ASCII of key pressed
- rd_idx  in  4  renderer slot select
- rd_valid  out  1  slot rd_idx occupied
- rd_ch  out  8  slot character
- rd_x  out  9  slot row
- rd_y  out  10  slot column
- slot_valid  out  SLOTS  occupancy vector
- hit  out  1  one-cycle pulse on a hit
- wrong  out  1  one-cycle pulse on a non-matching key
- miss  out  1  one-cycle pulse when >=1 character reaches the bottom
- drop  out  1  one-cycle pulse when a spawn is discarded (all slots full)
- hit_count  out  16  saturating hit counter
- miss_count  out  16  saturating miss counter
- game_over  out  1  high in OVER state

Behaviour:
- States:
  - IDLE: after reset; -> RUN on the first cycle with enable=1.
  - RUN: normal operation; -> OVER when miss_count >= MISS_LIMIT, evaluated on the registered count.
  - OVER: frozen; slots hold, pulses 0, inputs ignored, game_over=1; exits only via rst.
- Reset:
  - All slot_valid=0; slot ch/x/y/speed=0; counters=0; spawn_cnt=0; spawn_pending=0.
  - hit/wrong/miss/drop=0; game_over=0; state=IDLE.
  - rst mid-operation clears everything in the same edge; no pulse is emitted for slots discarded by reset.
- enable=0 in RUN: no movement, spawn counting, spawning or key handling. Pulses forced 0 and state held.
- Spawn timer: spawn_cnt increments on frame_tick. At SPAWN_INTERVAL-1 it wraps to 0 and sets spawn_pending.
- Spawn execution:
  - Occurs on the first cycle with spawn_pending=1, frame_tick=0 and key_valid=0; pending otherwise holds.
  - Target is the lowest-index free slot, loaded with gen_ch, gen_x, gen_y, and speed = (gen_speed==0 ? 1 : gen_speed).
  - spawn_pending clears.
  - If no slot is free: nothing is loaded, pending clears, and drop pulses the next cycle.
- Motion on frame_tick: every valid slot computes nx = x + speed in 10 bits.
  - If nx >= X_LIMIT, the slot is cleared and counts as a miss.
  - Otherwise x <= nx[8:0].
  - miss pulses once per tick regardless of how many slots retire.
  - miss_count += number retired that tick, saturating at 16'hFFFF.
- Key handling on key_valid: key_code is compared against ch of all valid slots, using state before this cycle's motion.
  - On a match, the lowest matching index is cleared; hit pulses and hit_count increments (saturating).
  - On no match, wrong pulses.
  - Only one slot is cleared per keypress.
- Same-cycle key and frame_tick: key evaluated first. A slot hit this cycle does not move and is never counted as a miss. Other slots move normally.
- Pulse timing: hit/wrong/miss/drop are registered and asserted exactly one cycle after the triggering edge. slot_valid and counters update on that same edge.
- Read port: rd_* is combinational from slot registers. rd_idx >= SLOTS returns rd_valid=0 and zeros on data.
- x width: stored x is 9 bits; the 10-bit compare prevents wrap for X_LIMIT up to 511.

Test Plan:
- rst 2 cycles, enable=1, SPAWN_INTERVAL=2, 4 frame_ticks with gen_ch=8'h41, gen_speed=0, gen_x=0, gen_y=100 -> slots 0,1 valid, ch=8'h41, speed coerced to 1; slot0 x=2 and slot1 x=0 after the ticks following each spawn.
- Slots 0,2 hold 'B', slot 1 holds 'C'; key_valid with 8'h42 -> slot0 cleared, slot2 retained, hit=1 one cycle later, hit_count=1; key 8'h5A -> wrong=1, no slot change.
- Two slots at x=458 speed 3, X_LIMIT=460, one frame_tick -> both cleared, single miss pulse, miss_count=2.
- Same cycle: key matches slot at x=458 speed 3 and frame_tick -> hit=1, miss=0, miss_count unchanged.
- All SLOTS full, spawn falls due -> drop=1 for one cycle, slot contents unchanged, spawn_cnt restarted.
- miss_count reaches MISS_LIMIT -> game_over=1 and further ticks/keys change nothing; rst mid-run with 5 slots valid -> next cycle slot_valid=0, counters 0, state IDLE, no pulses.
